maze_game_ctrl: RTL and testbench

- Game-flow controller for the 8x8 maze game: idle, self-test, map load, play, win and lose.
- Owns player position, step counter and countdown timer.
- Sequences wall lookups through the shared map-ROM read port.
- Drives a display-mode code consumed by the matrix and 7-seg scan drivers.

---
 rtl/maze_game_ctrl_if.sv | 9 +
 rtl/maze_game_ctrl.sv | 121 ++++++++++++
 tb/tb_maze_game_ctrl.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/maze_game_ctrl_if.sv
// maze_game_ctrl_if: map-ROM read port shared by the game controller and the maze ROM
interface maze_game_ctrl_if;
   logic       rd_map;
   logic [2:0] rd_row;
   logic [2:0] rd_col;
   logic       wall_bit;
   modport master (output rd_map, rd_row, rd_col, input wall_bit);
   modport slave (input rd_map, rd_row, rd_col, output wall_bit);
endinterface

// File: rtl/maze_game_ctrl.sv
// maze_game_ctrl: 8x8 maze game flow controller; define MAZE_BEST_SCORE_EN for per-map best step count
module maze_game_ctrl #(
   parameter int         TIME_LIMIT = 30,
   parameter int         STEP_MAX   = 99,
   parameter logic [5:0] START1     = 6'b110_111,
   parameter logic [5:0] GOAL1      = 6'b000_000,
   parameter logic [5:0] START2     = 6'b111_110,
   parameter logic [5:0] GOAL2      = 6'b001_111
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             self_exa,
   input  logic             change_map,
   input  logic             restart,
   input  logic [3:0]       move,
   input  logic             tick_1hz,
   maze_game_ctrl_if.master rom,
   output logic [2:0]       pos_row,
   output logic [2:0]       pos_col,
   output logic [4:0]       time_left,
   output logic [6:0]       steps,
   output logic [2:0]       disp_mode,
   output logic [6:0]       best_steps
);
   localparam logic [4:0] TL   = 5'(TIME_LIMIT);
   localparam logic [6:0] SMAX = 7'(STEP_MAX);
   typedef enum logic [2:0] {IDLE, TEST, LOAD, PLAY, CHK1, CHK2, WIN, LOSE} state_t;
   state_t     state, state_nx;
   logic [2:0] tgt_row, tgt_col, disp_nx;
   logic [6:0] steps_inc;
   logic       off_grid, try_move, expire, at_goal, load, run, issue, commit;

   assign tgt_row   = move[0] ? pos_row + 3'd1 : move[1] ? pos_row - 3'd1 : pos_row;
   assign tgt_col   = (move[0] | move[1]) ? pos_col : move[2] ? pos_col - 3'd1 : pos_col + 3'd1;
   assign off_grid  = move[0] ? pos_row == 3'd7 : move[1] ? pos_row == 3'd0 :
                      move[2] ? pos_col == 3'd0 : pos_col == 3'd7;
   assign try_move  = |move && !off_grid;
   assign expire    = tick_1hz && time_left <= 5'd1;
   assign at_goal   = {rom.rd_row, rom.rd_col} == (rom.rd_map ? GOAL2 : GOAL1);
   assign steps_inc = steps >= SMAX ? steps : steps + 7'd1;
   assign disp_nx   = state_nx == IDLE ? 3'd0 :
                      state_nx == TEST ? (state != TEST ? 3'd1 : tick_1hz ? 3'd3 - disp_mode : disp_mode) :
                      state_nx == WIN  ? 3'd5 : state_nx == LOSE ? 3'd4 : 3'd3;

   // state register
   always_ff @(posedge clk or negedge rst)
      if (!rst) state <= IDLE;
      else state <= state_nx;

   // next state and datapath strobes; start=0 overrides everything, restart abandons any check
   always_comb begin
      state_nx = state;
      load     = 1'b0;
      run      = 1'b0;
      issue    = 1'b0;
      commit   = 1'b0;
      if (!start)
         state_nx = self_exa ? TEST : IDLE;
      else
         case (state)
            IDLE, TEST: state_nx = LOAD;
            LOAD: begin
               state_nx = PLAY;
               load     = 1'b1;
            end
            WIN, LOSE: state_nx = restart ? LOAD : state;
            default:
               if (restart)
                  state_nx = LOAD;
               else begin
                  run      = 1'b1;
                  commit   = state == CHK2 && !rom.wall_bit;
                  issue    = state == PLAY && try_move && !expire;
                  state_nx = commit && at_goal ? WIN : expire ? LOSE : issue ? CHK1 :
                             state == CHK1 ? CHK2 : PLAY;
               end
         endcase
   end

   // game registers: reload in LOAD, latch target on accepted move, commit on a clear wall check
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         rom.rd_map <= 1'b0;
         rom.rd_row <= 3'd0;
         rom.rd_col <= 3'd0;
         pos_row    <= 3'd0;
         pos_col    <= 3'd0;
         time_left  <= 5'd0;
         steps      <= 7'd0;
         disp_mode  <= 3'd0;
      end else begin
         disp_mode <= disp_nx;
         if (load) begin
            rom.rd_map           <= change_map;
            {pos_row, pos_col}   <= change_map ? START2 : START1;
            time_left            <= TL;
            steps                <= 7'd0;
         end
         if (issue) {rom.rd_row, rom.rd_col} <= {tgt_row, tgt_col};
         if (commit) begin
            {pos_row, pos_col} <= {rom.rd_row, rom.rd_col};
            steps              <= steps_inc;
         end
         if (run && tick_1hz && time_left != 5'd0) time_left <= time_left - 5'd1;
      end

`ifdef MAZE_BEST_SCORE_EN
   logic [6:0] best [2];
   // lowest winning step count per map, updated on the commit that enters WIN; only rst clears it
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         best[0] <= 7'd127;
         best[1] <= 7'd127;
      end else if (commit && at_goal && steps_inc < best[rom.rd_map])
         best[rom.rd_map] <= steps_inc;
   assign best_steps = best[rom.rd_map];
`else
   assign best_steps = 7'd127;
`endif
endmodule

// File: tb/tb_maze_game_ctrl.sv
// tb_maze_game_ctrl: directed and randomized checks of maze_game_ctrl against a rule-level game model
`timescale 1ns/1ps
module tb_maze_game_ctrl;
   logic       clk = 1'b0, rst = 1'b0, start = 1'b0, self_exa = 1'b0, change_map = 1'b0;
   logic       restart = 1'b0, tick_1hz = 1'b0;
   logic [3:0] move = 4'd0;
   logic [2:0] pos_row, pos_col, disp_mode;
   logic [4:0] time_left;
   logic [6:0] steps, best_steps;
   bit         wall_mem [2][8][8];
   int         checks = 0, errors = 0;

   // game model: phase names and plain integers
   string ph;
   int m_row, m_col, m_t, m_s, m_map, m_rr, m_rc, m_disp, left;
   int best [2];
   int start_r [2] = '{6, 7};
   int start_c [2] = '{7, 6};
   int goal_r  [2] = '{0, 1};
   int goal_c  [2] = '{0, 7};

   maze_game_ctrl_if rif();

   maze_game_ctrl dut (
      .clk(clk), .rst(rst), .start(start), .self_exa(self_exa), .change_map(change_map),
      .restart(restart), .move(move), .tick_1hz(tick_1hz), .rom(rif),
      .pos_row(pos_row), .pos_col(pos_col), .time_left(time_left), .steps(steps),
      .disp_mode(disp_mode), .best_steps(best_steps)
   );

   always #5 clk = ~clk;

   // maze ROM: one cycle read latency
   always @(posedge clk) rif.wall_bit <= wall_mem[rif.rd_map][rif.rd_row][rif.rd_col];

   task automatic model_reset();
      ph = "idle";
      m_row = 0; m_col = 0; m_t = 0; m_s = 0; m_map = 0; m_rr = 0; m_rc = 0; m_disp = 0; left = 0;
      best[0] = 127; best[1] = 127;
   endtask

   task automatic model_step();
      bit expired, won;
      int dr, dc;
      if (!start) begin
         if (!self_exa) begin ph = "idle"; m_disp = 0; end
         else if (ph != "test") begin ph = "test"; m_disp = 1; end
         else if (tick_1hz) m_disp = (m_disp == 1) ? 2 : 1;
         return;
      end
      if (ph == "idle" || ph == "test") ph = "load";
      else if (ph == "load") begin
         m_map = int'(change_map);
         m_row = start_r[m_map]; m_col = start_c[m_map];
         m_t = 30; m_s = 0; ph = "play";
      end else if (restart) ph = "load";
      else if (ph == "play" || ph == "chk") begin
         expired = tick_1hz && m_t == 1;
         if (tick_1hz && m_t > 0) m_t--;
         won = 0;
         if (ph == "chk") begin
            left--;
            if (left == 0) begin
               ph = "play";
               if (!wall_mem[m_map][m_rr][m_rc]) begin
                  m_row = m_rr; m_col = m_rc;
                  m_s = (m_s + 1 > 99) ? 99 : m_s + 1;
                  won = (m_row == goal_r[m_map]) && (m_col == goal_c[m_map]);
               end
            end
         end else if (move != 4'd0 && !expired) begin
            dr = move[0] ? 1 : move[1] ? -1 : 0;
            dc = (move[0] | move[1]) ? 0 : move[2] ? -1 : 1;
            if (m_row + dr >= 0 && m_row + dr <= 7 && m_col + dc >= 0 && m_col + dc <= 7) begin
               m_rr = m_row + dr; m_rc = m_col + dc; ph = "chk"; left = 2;
            end
         end
         if (won) begin
            ph = "win";
            if (m_s < best[m_map]) best[m_map] = m_s;
         end else if (expired) ph = "lose";
      end
      m_disp = (ph == "win") ? 5 : (ph == "lose") ? 4 : 3;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic compare_all();
      chk("pos_row", 32'(pos_row), m_row);
      chk("pos_col", 32'(pos_col), m_col);
      chk("time_left", 32'(time_left), m_t);
      chk("steps", 32'(steps), m_s);
      chk("disp_mode", 32'(disp_mode), m_disp);
      chk("rd_map", 32'(rif.rd_map), m_map);
      chk("rd_row", 32'(rif.rd_row), m_rr);
      chk("rd_col", 32'(rif.rd_col), m_rc);
`ifdef MAZE_BEST_SCORE_EN
      chk("best_steps", 32'(best_steps), best[m_map]);
`else
      chk("best_steps", 32'(best_steps), 127);
`endif
   endtask

   task automatic cyc(input logic [3:0] mv = 4'd0, input logic tk = 1'b0, input logic rs = 1'b0);
      move = mv; tick_1hz = tk; restart = rs;
      @(posedge clk);
      model_step();
      #1;
      move = 4'd0; tick_1hz = 1'b0; restart = 1'b0;
      compare_all();
   endtask

   task automatic go(input logic [3:0] mv, input int n);
      for (int i = 0; i < n; i++) begin
         cyc(mv); cyc(); cyc();
      end
   endtask

   initial begin
      model_reset();
      #23 compare_all();
      @(posedge clk); #1 rst = 1'b1;
      cyc(); cyc();
      // load map 0
      start = 1'b1; change_map = 1'b0;
      cyc(); cyc();
      chk("load_pos", 32'({pos_row, pos_col}), 32'h37);
      chk("load_time", 32'(time_left), 30);
      chk("load_disp", 32'(disp_mode), 3);
      // wall blocks, grid edges block
      wall_mem[0][5][7] = 1'b1;
      go(4'b0010, 1);
      wall_mem[0][5][7] = 1'b0;
      chk("wall_steps", 32'(steps), 0);
      go(4'b0001, 1);
      cyc(4'b0001); cyc(4'b1000);
      go(4'b0010, 1);
      // legal moves and priority
      go(4'b0100, 1);
      go(4'b0101, 1);
      go(4'b0010, 1);
      // restart then win map 0
      cyc(4'd0, 1'b0, 1'b1); cyc();
      go(4'b0010, 6); go(4'b0100, 7);
      chk("win_steps", 32'(steps), 13);
      chk("win_disp", 32'(disp_mode), 5);
      go(4'b0010, 2);
      cyc(4'd0, 1'b1);
      // lose on timeout
      cyc(4'd0, 1'b0, 1'b1); cyc();
      repeat (30) cyc(4'd0, 1'b1);
      chk("lose_time", 32'(time_left), 0);
      chk("lose_disp", 32'(disp_mode), 4);
      cyc(4'd0, 1'b1);
      // last tick lands on the winning commit
      cyc(4'd0, 1'b0, 1'b1); cyc();
      repeat (29) cyc(4'd0, 1'b1);
      go(4'b0010, 6); go(4'b0100, 6);
      cyc(4'b0100); cyc(); cyc(4'd0, 1'b1);
      chk("tie_disp", 32'(disp_mode), 5);
      // map 1
      change_map = 1'b1;
      cyc(4'd0, 1'b0, 1'b1); cyc();
      chk("map1_pos", 32'({pos_row, pos_col}), 32'h3e);
      change_map = 1'b0;
      go(4'b1000, 1); go(4'b0010, 6);
      chk("map1_win", 32'(disp_mode), 5);
      // self-test display
      start = 1'b0; self_exa = 1'b1;
      cyc(); cyc(4'd0, 1'b1); cyc(4'd0, 1'b1); cyc();
      // abort from CHK1
      start = 1'b1; self_exa = 1'b0;
      cyc(); cyc(); cyc(4'b0010);
      start = 1'b0;
      cyc();
      chk("abort_idle", 32'(disp_mode), 0);
      start = 1'b1;
      cyc(); cyc(); cyc(4'b0100);
      start = 1'b0; self_exa = 1'b1;
      cyc(); self_exa = 1'b0;
      // randomized play on random mazes
      foreach (wall_mem[m, r, c]) wall_mem[m][r][c] = ($urandom_range(3) == 0);
      for (int i = 0; i < 4000; i++) begin
         start      = ($urandom_range(99) < 2) ? 1'b0 : 1'b1;
         self_exa   = 1'($urandom_range(1));
         change_map = 1'($urandom_range(1));
         cyc(($urandom_range(2) == 0) ? 4'($urandom_range(15)) : 4'd0,
             $urandom_range(24) == 0, $urandom_range(199) == 0);
      end
      // asynchronous reset mid-play
      start = 1'b1;
      cyc(); cyc(); cyc(4'd0, 1'b0, 1'b1); cyc(); cyc(4'b0010);
      #2 rst = 1'b0;
      #1 model_reset();
      compare_all();
      chk("rst_best", 32'(best_steps), 127);
      @(posedge clk); #1 rst = 1'b1;
      cyc(); cyc(); go(4'b0100, 1);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
